// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Serves CPU word loads/stores and issues block reads/writes to data memory on misses.
module dcache_wb_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int BLOCK_BITS = 256,
  parameter int NUM_SETS   = 32,
  parameter int OFFSET_W   = 5,
  parameter int INDEX_W    = 5,
  parameter int MEM_ADDR_W = 27
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_ren,
  input  logic                  cpu_wen,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [WORD_W-1:0]     cpu_wdata,
  input  logic [3:0]            cpu_byte_en,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [MEM_ADDR_W-1:0] mem_block_address,
  output logic [BLOCK_BITS-1:0] mem_din,
  input  logic                  mem_read_ready,
  input  logic                  mem_write_done,
  input  logic [BLOCK_BITS-1:0] mem_dout
);

  localparam int TAG_W  = ADDR_W - OFFSET_W - INDEX_W;
  localparam int WSEL_W = OFFSET_W - 2;

  typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

  state_t state, state_next;

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [BLOCK_BITS-1:0] data_q [NUM_SETS];

  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_index;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [WSEL_W-1:0]     req_wsel;
  logic [BLOCK_BITS-1:0] req_line;
  logic                  req;
  logic                  hit;
  logic                  wr_hit;
  logic                  fill;
  logic                  miss_start;
  logic                  unused_addr_bits;

  function automatic logic [WORD_W-1:0] extract_word(input logic [BLOCK_BITS-1:0] blk,
                                                     input logic [WSEL_W-1:0] ws);
    return blk[ws*WORD_W +: WORD_W];
  endfunction

  function automatic logic [BLOCK_BITS-1:0] merge_word(input logic [BLOCK_BITS-1:0] blk,
                                                       input logic [WSEL_W-1:0] ws,
                                                       input logic [WORD_W-1:0] wdata,
                                                       input logic [3:0] be);
    logic [BLOCK_BITS-1:0] r;
    r = blk;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[ws*WORD_W + b*8 +: 8] = wdata[b*8 +: 8];
    end
    return r;
  endfunction

  assign req_tag    = cpu_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign req_index  = cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_wsel   = cpu_addr[OFFSET_W-1:2];
  assign req_line   = data_q[req_index];
  assign req        = cpu_ren | cpu_wen;
  assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign wr_hit     = (state == IDLE) && cpu_wen && hit;
  assign fill       = (state == ALLOC) && mem_read_ready;
  assign miss_start = (state == IDLE) && req && !hit;
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Control state: FSM and per-line valid/dirty bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state <= state_next;
      if (fill) begin
        valid_q[miss_index] <= 1'b1;
        dirty_q[miss_index] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[req_index] <= 1'b1;
      end
    end
  end

  // Tag/data arrays and the miss address latch carry no reset; valid gates their use
  always_ff @(posedge clock) begin
    if (miss_start) begin
      miss_tag   <= req_tag;
      miss_index <= req_index;
    end
    if (fill) begin
      data_q[miss_index] <= mem_dout;
      tag_q[miss_index]  <= miss_tag;
    end else if (wr_hit) begin
      data_q[req_index] <= merge_word(req_line, req_wsel, cpu_wdata, cpu_byte_en);
    end
  end

  always_comb begin
    state_next        = state;
    cpu_stall         = 1'b0;
    cpu_rdata         = '0;
    mem_ren           = 1'b0;
    mem_wen           = 1'b0;
    mem_block_address = '0;
    mem_din           = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (!cpu_wen) cpu_rdata = extract_word(req_line, req_wsel);
          end else begin
            cpu_stall  = 1'b1;
            state_next = (valid_q[req_index] && dirty_q[req_index]) ? WB : ALLOC;
          end
        end
      end
      WB: begin
        cpu_stall         = 1'b1;
        mem_wen           = 1'b1;
        mem_block_address = {tag_q[miss_index], miss_index};
        mem_din           = data_q[miss_index];
        if (mem_write_done) state_next = ALLOC;
      end
      ALLOC: begin
        cpu_stall         = 1'b1;
        mem_ren           = 1'b1;
        mem_block_address = {miss_tag, miss_index};
        if (mem_read_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Testbench for dcache_wb_ctrl: behavioural block memory with fixed latency,
// table of CPU transactions with hand-computed results, plus a reset-during-fill sequence.
module tb_dcache_wb_ctrl;

  localparam int LAT = 5;

  logic         clock;
  logic         reset;
  logic         cpu_ren;
  logic         cpu_wen;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_byte_en;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_ren;
  logic         mem_wen;
  logic [26:0]  mem_block_address;
  logic [255:0] mem_din;
  logic         mem_read_ready;
  logic         mem_write_done;
  logic [255:0] mem_dout;

  logic         resp_en;
  logic         inject_ready;
  logic [255:0] mem_blk [int];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_cyc;
    logic        exp_wb;
    logic        exp_al;
    logic [26:0] exp_wb_addr;
    logic [26:0] exp_al_addr;
  } vec_t;

  vec_t vecs[$];

  dcache_wb_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_ren           (cpu_ren),
    .cpu_wen           (cpu_wen),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_byte_en       (cpu_byte_en),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .mem_ren           (mem_ren),
    .mem_wen           (mem_wen),
    .mem_block_address (mem_block_address),
    .mem_din           (mem_din),
    .mem_read_ready    (mem_read_ready),
    .mem_write_done    (mem_write_done),
    .mem_dout          (mem_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Untouched blocks read as word i = 0xC000_0000 | (block << 4) | i
  function automatic logic [255:0] get_blk(input int a);
    logic [255:0] b;
    if (mem_blk.exists(a)) return mem_blk[a];
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = 32'hC000_0000 | (a << 4) | i;
    return b;
  endfunction

  // Memory responder: answers an asserted request after LAT cycles with a one-cycle pulse
  initial begin
    int cnt;
    logic [255:0] pre;
    cnt = 0;
    mem_read_ready = 1'b0;
    mem_write_done = 1'b0;
    mem_dout = '0;
    pre = get_blk(32'h20);
    pre[63:32] = 32'hDEADBEEF;
    mem_blk[32'h20] = pre;
    forever begin
      @(negedge clock);
      mem_read_ready = inject_ready;
      mem_write_done = 1'b0;
      if (resp_en && (mem_ren || mem_wen)) begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          if (mem_wen) begin
            mem_blk[int'(mem_block_address)] = mem_din;
            mem_write_done = 1'b1;
          end else begin
            mem_dout = get_blk(int'(mem_block_address));
            mem_read_ready = 1'b1;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic chk_rd, input logic [31:0] exp_rd, input int exp_cyc,
                     input logic exp_wb, input logic exp_al,
                     input logic [26:0] wba, input logic [26:0] ala);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.be = be;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_cyc = exp_cyc;
    v.exp_wb = exp_wb; v.exp_al = exp_al; v.exp_wb_addr = wba; v.exp_al_addr = ala;
    vecs.push_back(v);
  endtask

  task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int cyc, output logic saw_wb, output logic saw_al,
                        output logic [26:0] wb_a, output logic [26:0] al_a,
                        output logic [31:0] rd);
    cyc = 0; saw_wb = 0; saw_al = 0; wb_a = '0; al_a = '0; rd = '0;
    @(negedge clock); #1;
    cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_byte_en = be;
    forever begin
      #2;
      chk("ren_wen_exclusive", 64'(mem_ren & mem_wen), 64'd0);
      if (mem_wen && !saw_wb) begin saw_wb = 1'b1; wb_a = mem_block_address; end
      if (mem_ren && !saw_al) begin saw_al = 1'b1; al_a = mem_block_address; end
      if (!cpu_stall) begin
        rd = cpu_rdata;
        break;
      end
      cyc++;
      if (cyc > 100) begin
        tests++;
        fails++;
        $display("FAIL stall_timeout: actual=stalled required=released within 100 cycles");
        break;
      end
      @(negedge clock); #1;
    end
    @(negedge clock); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
  endtask

  initial begin
    int cyc;
    logic saw_wb, saw_al;
    logic [26:0] wb_a, al_a;
    logic [31:0] rd;
    logic [255:0] blk;
    vec_t v;

    reset = 1'b1;
    cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_en = '0;
    resp_en = 1'b1;
    inject_ready = 1'b0;

    //   ren  wen  addr          wdata         be       chk rd            cyc wb al wb_addr al_addr
    add(1'b1, 1'b0, 32'h0000_0404, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 6,  0, 1, 27'h00, 27'h20);
    add(1'b1, 1'b0, 32'h0000_0404, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 0,  0, 0, 27'h00, 27'h00);
    add(1'b0, 1'b1, 32'h0000_0404, 32'h11223344, 4'b0011, 0, 32'h0,        0,  0, 0, 27'h00, 27'h00);
    add(1'b1, 1'b0, 32'h0000_0404, 32'h0,        4'b0000, 1, 32'hDEAD3344, 0,  0, 0, 27'h00, 27'h00);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 1, 32'hC0000001, 11, 1, 1, 27'h20, 27'h00);
    add(1'b1, 1'b0, 32'h0000_0404, 32'h0,        4'b0000, 1, 32'hDEAD3344, 6,  0, 1, 27'h00, 27'h20);
    add(1'b0, 1'b1, 32'h0000_0404, 32'hFFFFFFFF, 4'b0000, 0, 32'h0,        0,  0, 0, 27'h00, 27'h00);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 1, 32'hC0000001, 11, 1, 1, 27'h20, 27'h00);
    add(1'b1, 1'b0, 32'h0000_03FC, 32'h0,        4'b0000, 1, 32'hC00001F7, 6,  0, 1, 27'h00, 27'h1F);
    add(1'b0, 1'b1, 32'h0000_03FC, 32'hCAFEF00D, 4'b1111, 0, 32'h0,        0,  0, 0, 27'h00, 27'h00);
    add(1'b1, 1'b0, 32'h0000_03FC, 32'h0,        4'b0000, 1, 32'hCAFEF00D, 0,  0, 0, 27'h00, 27'h00);
    add(1'b1, 1'b0, 32'h0000_07FC, 32'h0,        4'b0000, 1, 32'hC00003F7, 11, 1, 1, 27'h1F, 27'h3F);
    add(1'b1, 1'b1, 32'h0000_07FC, 32'hAB000000, 4'b1000, 0, 32'h0,        0,  0, 0, 27'h00, 27'h00);
    add(1'b1, 1'b0, 32'h0000_07FC, 32'h0,        4'b0000, 1, 32'hAB0003F7, 0,  0, 0, 27'h00, 27'h00);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 1, 32'hC0000001, 0,  0, 0, 27'h00, 27'h00);

    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    #2;
    chk("reset_stall", 64'(cpu_stall), 64'd0);
    chk("reset_mem_ren", 64'(mem_ren), 64'd0);
    chk("reset_mem_wen", 64'(mem_wen), 64'd0);
    chk("reset_rdata", 64'(cpu_rdata), 64'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      do_req(v.ren, v.wen, v.addr, v.wdata, v.be, cyc, saw_wb, saw_al, wb_a, al_a, rd);
      chk($sformatf("v%0d_stall_cycles", i), 64'(cyc), 64'(v.exp_cyc));
      chk($sformatf("v%0d_wb_seen", i), 64'(saw_wb), 64'(v.exp_wb));
      chk($sformatf("v%0d_alloc_seen", i), 64'(saw_al), 64'(v.exp_al));
      if (v.chk_rd) chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(v.exp_rd));
      if (v.exp_wb) chk($sformatf("v%0d_wb_addr", i), 64'(wb_a), 64'(v.exp_wb_addr));
      if (v.exp_al) chk($sformatf("v%0d_alloc_addr", i), 64'(al_a), 64'(v.exp_al_addr));
    end

    // Written-back victim data reached memory intact
    blk = get_blk(32'h20);
    chk("wb_data_blk20_w1", 64'(blk[63:32]), 64'h0000_0000_DEAD3344);
    blk = get_blk(32'h1F);
    chk("wb_data_blk1f_w7", 64'(blk[255:224]), 64'h0000_0000_CAFEF00D);

    // Reset while a fill is outstanding
    resp_en = 1'b0;
    @(negedge clock); #1;
    cpu_ren = 1'b1; cpu_addr = 32'h0000_0404;
    repeat (3) @(negedge clock);
    #3;
    chk("rst_seq_alloc_ren", 64'(mem_ren), 64'd1);
    chk("rst_seq_alloc_addr", 64'(mem_block_address), 64'h20);
    chk("rst_seq_alloc_stall", 64'(cpu_stall), 64'd1);
    #1;
    reset = 1'b1;
    cpu_ren = 1'b0;
    #1;
    chk("rst_seq_ren_drop", 64'(mem_ren), 64'd0);
    chk("rst_seq_wen_low", 64'(mem_wen), 64'd0);
    chk("rst_seq_stall", 64'(cpu_stall), 64'd0);
    chk("rst_seq_rdata", 64'(cpu_rdata), 64'd0);
    @(negedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    inject_ready = 1'b1;
    @(negedge clock); #1;
    inject_ready = 1'b0;
    resp_en = 1'b1;

    do_req(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'b0, cyc, saw_wb, saw_al, wb_a, al_a, rd);
    chk("post_rst_0404_cycles", 64'(cyc), 64'd6);
    chk("post_rst_0404_wb_seen", 64'(saw_wb), 64'd0);
    chk("post_rst_0404_rdata", 64'(rd), 64'h0000_0000_DEAD3344);
    do_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'b0, cyc, saw_wb, saw_al, wb_a, al_a, rd);
    chk("post_rst_0004_cycles", 64'(cyc), 64'd6);
    chk("post_rst_0004_wb_seen", 64'(saw_wb), 64'd0);
    chk("post_rst_0004_rdata", 64'(rd), 64'h0000_0000_C0000001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
